// File: rtl/sd_cmd_responder.sv
// sd_cmd_responder
//   SD-card side CMD line engine. Receives 48-bit host command frames,
//   checks the transmission bit, the end bit and the CRC7, and reports the
//   command. If the user asks for one, it then sends an R1 (48-bit) or
//   R2 (136-bit) response after NCR idle clocks.
//
// Ports
//   sdClk     in   card clock; every state update and sample is on its rising edge
//   sysRstN   in   asynchronous active-low reset (release resynchronised to sdClk)
//   sdCmdIn   in   CMD line as driven by the host
//   sdCmdOut  out  response bit driven onto CMD
//   sdCmdEn   out  drive enable for sdCmdOut (pad tristate is ~sdCmdEn)
//   cmdIndex  out  index of the last accepted command
//   cmdArg    out  argument of the last accepted command
//   cmdValid  out  one-cycle pulse when a frame passes every check
//   cmdError  out  one-cycle pulse when a frame fails a check
//   rspType   in   00 none, 01 R1, 10 R2, 11 none; sampled during cmdValid
//   rspData   in   R1 status in [31:0]; R2 CID/CSD bits 127:8 in [119:0]
//   busy      out  high whenever the engine is not idle
module sd_cmd_responder #(
  parameter int NCR = 2
) (
  input  logic         sdClk,
  input  logic         sysRstN,
  input  logic         sdCmdIn,
  output logic         sdCmdOut,
  output logic         sdCmdEn,
  output logic [5:0]   cmdIndex,
  output logic [31:0]  cmdArg,
  output logic         cmdValid,
  output logic         cmdError,
  input  logic [1:0]   rspType,
  input  logic [119:0] rspData,
  output logic         busy
);

  typedef enum logic [2:0] {IDLE, RX, CHECK, WAIT, TX} stateT;

  // CHECK already provides one undriven cycle, so WAIT lasts NCR-1 cycles.
  localparam logic [7:0] NCR_LAST = 8'(NCR - 2);
  localparam logic [6:0] CRC_POLY = 7'h09;

  stateT        r_state;
  stateT        w_nextState;
  logic [1:0]   r_rstSync;
  logic         w_rstN;
  logic [7:0]   r_bitCnt;
  logic [46:0]  r_rxShift;
  logic [6:0]   r_crc;
  logic [126:0] r_txShift;
  logic         r_isR2;
  logic [5:0]   r_cmdIndex;
  logic [31:0]  r_cmdArg;
  logic         r_cmdValid;
  logic         r_cmdError;
  logic         r_cmdOut;
  logic         r_cmdEn;
  logic         r_busy;

  logic         w_rxCrcOk;
  logic         w_rspActive;
  logic [7:0]   w_nextBit;
  logic [7:0]   w_dataLast;
  logic [7:0]   w_crcFirst;
  logic [7:0]   w_frameLast;
  logic         w_cmdValidNext;
  logic         w_cmdErrorNext;
  logic         w_loadTx;
  logic         w_txBit;

  // One step of the serial CRC7 (x^7 + x^3 + 1) generator.
  function automatic logic [6:0] crc7Step(input logic [6:0] crc, input logic bitIn);
    logic fb;
    fb = bitIn ^ crc[6];
    return {crc[5:0], 1'b0} ^ (fb ? CRC_POLY : 7'h00);
  endfunction

  // Reset asserts immediately; deassertion is delayed two sdClk edges so
  // that every flop leaves reset on the same clock.
  always_ff @(posedge sdClk or negedge sysRstN) begin
    if (!sysRstN) r_rstSync <= 2'b00;
    else          r_rstSync <= {r_rstSync[0], 1'b1};
  end
  assign w_rstN = r_rstSync[1];

  // r_rxShift holds frame bits 1..47 after the start bit, MSB first:
  // [46] transmission bit, [45:40] index, [39:8] argument, [7:1] CRC, [0] end bit.
  assign w_rxCrcOk   = r_rxShift[46] && r_rxShift[0] && (r_rxShift[7:1] == r_crc);
  assign w_rspActive = (rspType == 2'b01) || (rspType == 2'b10);

  // In TX, r_bitCnt is the index of the bit currently on the line. Bit 0 is
  // the start bit; bits 1..dataLast come from r_txShift, followed by 7 CRC
  // bits and the end bit. R2 leaves its 8-bit header out of the CRC.
  assign w_nextBit   = r_bitCnt + 8'd1;
  assign w_dataLast  = r_isR2 ? 8'd127 : 8'd39;
  assign w_crcFirst  = r_isR2 ? 8'd8   : 8'd1;
  assign w_frameLast = r_isR2 ? 8'd135 : 8'd47;

  always_ff @(posedge sdClk or negedge w_rstN) begin
    if (!w_rstN) r_state <= IDLE;
    else         r_state <= w_nextState;
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE:  if (!sdCmdIn) w_nextState = RX;
      RX:    if (r_bitCnt == 8'd46) w_nextState = CHECK;
      CHECK: w_nextState = w_rxCrcOk ? WAIT : IDLE;
      WAIT: begin
        // The response type is only looked at in the first WAIT cycle,
        // which is the cycle in which cmdValid is high.
        if (r_bitCnt == 8'd0 && !w_rspActive) w_nextState = IDLE;
        else if (r_bitCnt == NCR_LAST)         w_nextState = TX;
      end
      TX:    if (r_bitCnt == w_frameLast) w_nextState = IDLE;
      default: w_nextState = IDLE;
    endcase
  end

  // Decodes what the registered outputs should show in the next cycle.
  always_comb begin
    w_cmdValidNext = 1'b0;
    w_cmdErrorNext = 1'b0;
    w_loadTx       = 1'b0;
    w_txBit        = 1'b1;
    case (r_state)
      CHECK: begin
        w_cmdValidNext = w_rxCrcOk;
        w_cmdErrorNext = !w_rxCrcOk;
      end
      WAIT: begin
        w_loadTx = (r_bitCnt == 8'd0);
        w_txBit  = 1'b0;
      end
      TX: begin
        if (w_nextBit <= w_dataLast)              w_txBit = r_txShift[126];
        else if (w_nextBit <= w_dataLast + 8'd7)  w_txBit = r_crc[6];
        else                                      w_txBit = 1'b1;
      end
      default: ;
    endcase
  end

  // The bit counter restarts on every state change so each state counts from zero.
  always_ff @(posedge sdClk or negedge w_rstN) begin
    if (!w_rstN) begin
      r_bitCnt <= 8'd0;
    end else if (w_nextState != r_state) begin
      r_bitCnt <= 8'd0;
    end else if (r_state == RX || r_state == WAIT || r_state == TX) begin
      r_bitCnt <= w_nextBit;
    end
  end

  // Receive shifter plus the CRC register, which is shared by both directions.
  always_ff @(posedge sdClk or negedge w_rstN) begin
    if (!w_rstN) begin
      r_rxShift <= '0;
      r_crc     <= 7'd0;
    end else begin
      case (r_state)
        IDLE: begin
          r_rxShift <= '0;
          r_crc     <= 7'd0;
        end
        RX: begin
          r_rxShift <= {r_rxShift[45:0], sdCmdIn};
          if (r_bitCnt <= 8'd38) r_crc <= crc7Step(r_crc, sdCmdIn);
        end
        WAIT: r_crc <= 7'd0;
        TX: begin
          if (w_nextBit <= w_dataLast) begin
            if (w_nextBit >= w_crcFirst) r_crc <= crc7Step(r_crc, r_txShift[126]);
          end else begin
            r_crc <= {r_crc[5:0], 1'b0};
          end
        end
        default: ;
      endcase
    end
  end

  // The response body is loaded once, in the cmdValid cycle, from the bits
  // that follow the start bit. R1 is left-aligned and padded with zeros.
  always_ff @(posedge sdClk or negedge w_rstN) begin
    if (!w_rstN) begin
      r_txShift <= '0;
      r_isR2    <= 1'b0;
    end else if (w_loadTx) begin
      r_isR2 <= (rspType == 2'b10);
      if (rspType == 2'b10) r_txShift <= {1'b0, 6'b111111, rspData};
      else                  r_txShift <= {1'b0, r_cmdIndex, rspData[31:0], 88'd0};
    end else if (r_state == TX && w_nextBit <= w_dataLast) begin
      r_txShift <= {r_txShift[125:0], 1'b0};
    end
  end

  // Registered outputs: the drive enable and line bit come straight from flops.
  always_ff @(posedge sdClk or negedge w_rstN) begin
    if (!w_rstN) begin
      r_cmdIndex <= 6'd0;
      r_cmdArg   <= 32'd0;
      r_cmdValid <= 1'b0;
      r_cmdError <= 1'b0;
      r_cmdOut   <= 1'b1;
      r_cmdEn    <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      r_cmdValid <= w_cmdValidNext;
      r_cmdError <= w_cmdErrorNext;
      r_cmdEn    <= (w_nextState == TX);
      r_cmdOut   <= (w_nextState == TX) ? w_txBit : 1'b1;
      r_busy     <= (w_nextState != IDLE);
      if (w_cmdValidNext) begin
        r_cmdIndex <= r_rxShift[45:40];
        r_cmdArg   <= r_rxShift[39:8];
      end
    end
  end

  assign sdCmdOut = r_cmdOut;
  assign sdCmdEn  = r_cmdEn;
  assign cmdIndex = r_cmdIndex;
  assign cmdArg   = r_cmdArg;
  assign cmdValid = r_cmdValid;
  assign cmdError = r_cmdError;
  assign busy     = r_busy;

endmodule

// File: tb/tb_sd_cmd_responder.sv
// tb_sd_cmd_responder
//   Scenario bench for sd_cmd_responder. Host frames and expected responses
//   are built from the frame layouts using a long-division CRC7.
module tb_sd_cmd_responder;

  localparam int NCR = 2;

  logic         sdClk = 1'b0;
  logic         sysRstN;
  logic         sdCmdIn;
  logic         sdCmdOut;
  logic         sdCmdEn;
  logic [5:0]   cmdIndex;
  logic [31:0]  cmdArg;
  logic         cmdValid;
  logic         cmdError;
  logic [1:0]   rspType;
  logic [119:0] rspData;
  logic         busy;

  int total = 0;
  int bad   = 0;

  // Per-cycle capture of DUT outputs, index 1 = cycle after the host end bit.
  logic capEn    [1:255];
  logic capOut   [1:255];
  logic capValid [1:255];
  logic capErr   [1:255];
  logic capBusy  [1:255];

  int           n, firstEn, lastEn, enCount, validAt, validCount, errAt, errCount;
  logic [135:0] got;

  // Model of the last accepted command.
  logic [5:0]  expIndex;
  logic [31:0] expArg;

  always #5 sdClk = ~sdClk;

  sd_cmd_responder #(.NCR(NCR)) dut (
    .sdClk(sdClk), .sysRstN(sysRstN), .sdCmdIn(sdCmdIn),
    .sdCmdOut(sdCmdOut), .sdCmdEn(sdCmdEn),
    .cmdIndex(cmdIndex), .cmdArg(cmdArg),
    .cmdValid(cmdValid), .cmdError(cmdError),
    .rspType(rspType), .rspData(rspData), .busy(busy)
  );

  // CRC7 by polynomial long division: append seven zeros, XOR 0x89 under each set bit.
  function automatic logic [6:0] crc7Model(input logic [135:0] msg, input int len);
    logic [142:0] w;
    w = {msg, 7'b0};
    for (int i = len + 6; i >= 7; i--)
      if (w[i]) w[i -: 8] = w[i -: 8] ^ 8'h89;
    return w[6:0];
  endfunction

  function automatic logic [47:0] hostFrame(input logic [5:0] idx, input logic [31:0] arg);
    logic [39:0] m;
    m = {2'b01, idx, arg};
    return {m, crc7Model({96'd0, m}, 40), 1'b1};
  endfunction

  task automatic expectedRsp(input logic [1:0] typ, input logic [5:0] idx, input logic [119:0] data,
                             output int len, output logic [135:0] bits);
    logic [39:0] m;
    len  = 0;
    bits = '0;
    if (typ == 2'b01) begin
      m    = {2'b00, idx, data[31:0]};
      bits = {88'd0, m, crc7Model({96'd0, m}, 40), 1'b1};
      len  = 48;
    end else if (typ == 2'b10) begin
      bits = {8'h3F, data, crc7Model({16'd0, data}, 120), 1'b1};
      len  = 136;
    end
  endtask

  // Caller must be at a negedge; returns at the negedge of the cycle after the end bit.
  task automatic sendFrame(input logic [47:0] f);
    for (int i = 47; i >= 0; i--) begin
      sdCmdIn = f[i];
      @(negedge sdClk);
    end
    sdCmdIn = 1'b1;
  endtask

  // Records outputs once per cycle; the host line is held low for lowCycles cycles.
  task automatic collect(input int maxCycles, input int lowCycles, input bit stopOnFall);
    bit seen;
    seen = 1'b0;
    n = 0;
    for (int k = 1; k <= maxCycles; k++) begin
      sdCmdIn     = (k <= lowCycles) ? 1'b0 : 1'b1;
      capEn[k]    = sdCmdEn;
      capOut[k]   = sdCmdOut;
      capValid[k] = cmdValid;
      capErr[k]   = cmdError;
      capBusy[k]  = busy;
      n = k;
      if (sdCmdEn) seen = 1'b1;
      if (stopOnFall && seen && !sdCmdEn) break;
      @(negedge sdClk);
    end
    sdCmdIn = 1'b1;
    firstEn = 0; lastEn = 0; enCount = 0; validAt = 0; validCount = 0;
    errAt = 0; errCount = 0; got = '0;
    for (int k = 1; k <= n; k++) begin
      if (capEn[k]) begin
        if (firstEn == 0) firstEn = k;
        lastEn = k;
        enCount++;
        got = {got[134:0], capOut[k]};
      end
      if (capValid[k]) begin
        validCount++;
        if (validAt == 0) validAt = k;
      end
      if (capErr[k]) begin
        errCount++;
        if (errAt == 0) errAt = k;
      end
    end
  endtask

  task automatic test_reset;
    sysRstN = 1'b0; sdCmdIn = 1'b1; rspType = 2'b00; rspData = '0;
    #12;
    total++; if (sdCmdEn !== 1'b0)  begin bad++; $display("[TB] FAIL reset_en: got %b expected 0", sdCmdEn); end
    total++; if (sdCmdOut !== 1'b1) begin bad++; $display("[TB] FAIL reset_out: got %b expected 1", sdCmdOut); end
    total++; if ({cmdValid, cmdError, busy} !== 3'b000)
      begin bad++; $display("[TB] FAIL reset_flags: got %b expected 000", {cmdValid, cmdError, busy}); end
    total++; if ({cmdIndex, cmdArg} !== 38'd0)
      begin bad++; $display("[TB] FAIL reset_cmd: got %h expected 0", {cmdIndex, cmdArg}); end
    @(negedge sdClk); sysRstN = 1'b1;
    repeat (3) @(negedge sdClk);
    expIndex = 6'd0; expArg = 32'd0;
  endtask

  task automatic test_no_response;
    rspType = 2'b00;
    sendFrame(48'h40_00000000_95);
    collect(8, 0, 1'b0);
    total++; if (validAt !== 2 || validCount !== 1)
      begin bad++; $display("[TB] FAIL none_valid: got at=%0d count=%0d expected at=2 count=1", validAt, validCount); end
    total++; if (enCount !== 0 || errCount !== 0)
      begin bad++; $display("[TB] FAIL none_drive: got en=%0d err=%0d expected 0 0", enCount, errCount); end
    total++; if ({cmdIndex, cmdArg} !== 38'd0)
      begin bad++; $display("[TB] FAIL none_cmd: got %h expected 0", {cmdIndex, cmdArg}); end
    total++; if (capBusy[3] !== 1'b0) begin bad++; $display("[TB] FAIL none_idle: got busy %b expected 0", capBusy[3]); end
  endtask

  task automatic test_r1;
    rspType = 2'b01; rspData = {88'd0, 32'h000001AA};
    sendFrame(48'h48_000001AA_87);
    collect(90, 0, 1'b1);
    expIndex = 6'd8; expArg = 32'h1AA;
    total++; if (validAt !== 2) begin bad++; $display("[TB] FAIL r1_valid_at: got %0d expected 2", validAt); end
    total++; if (firstEn !== NCR + 1) begin bad++; $display("[TB] FAIL r1_gap: got %0d expected %0d", firstEn, NCR + 1); end
    total++; if (enCount !== 48 || lastEn - firstEn + 1 !== 48)
      begin bad++; $display("[TB] FAIL r1_len: got %0d (span %0d) expected 48", enCount, lastEn - firstEn + 1); end
    total++; if (got[47:0] !== 48'h08_000001AA_13)
      begin bad++; $display("[TB] FAIL r1_frame: got %h expected 08000001aa13", got[47:0]); end
    total++; if (cmdIndex !== expIndex || cmdArg !== expArg)
      begin bad++; $display("[TB] FAIL r1_cmd: got %h/%h expected %h/%h", cmdIndex, cmdArg, expIndex, expArg); end
    total++; if (capBusy[n] !== 1'b0) begin bad++; $display("[TB] FAIL r1_idle: got busy %b expected 0", capBusy[n]); end
  endtask

  // Runs straight after a response so its start bit lands in the first idle cycle.
  task automatic test_back_to_back;
    logic [5:0]   idx;
    logic [31:0]  arg;
    int           len;
    logic [135:0] bits;
    idx = 6'($urandom_range(0, 63)); arg = $urandom;
    rspType = 2'b01; rspData = {88'd0, $urandom};
    expectedRsp(2'b01, idx, rspData, len, bits);
    sendFrame(hostFrame(idx, arg));
    collect(90, 0, 1'b1);
    expIndex = idx; expArg = arg;
    total++; if (validAt !== 2) begin bad++; $display("[TB] FAIL b2b_valid_at: got %0d expected 2", validAt); end
    total++; if (enCount !== len || got !== bits)
      begin bad++; $display("[TB] FAIL b2b_frame: got %0d bits %h expected %0d bits %h", enCount, got, len, bits); end
    total++; if (cmdIndex !== expIndex || cmdArg !== expArg)
      begin bad++; $display("[TB] FAIL b2b_cmd: got %h/%h expected %h/%h", cmdIndex, cmdArg, expIndex, expArg); end
  endtask

  task automatic test_bad_crc;
    rspType = 2'b01;
    sendFrame(48'h40_00000000_97);
    collect(10, 0, 1'b0);
    total++; if (errAt !== 2 || errCount !== 1)
      begin bad++; $display("[TB] FAIL badcrc_err: got at=%0d count=%0d expected at=2 count=1", errAt, errCount); end
    total++; if (validCount !== 0 || enCount !== 0)
      begin bad++; $display("[TB] FAIL badcrc_quiet: got valid=%0d en=%0d expected 0 0", validCount, enCount); end
    total++; if (cmdIndex !== expIndex || cmdArg !== expArg)
      begin bad++; $display("[TB] FAIL badcrc_cmd: got %h/%h expected %h/%h", cmdIndex, cmdArg, expIndex, expArg); end
  endtask

  task automatic test_r2;
    rspType = 2'b10; rspData = '0;
    sendFrame(48'h42_00000000_4D);
    collect(180, 0, 1'b1);
    expIndex = 6'd2; expArg = 32'd0;
    total++; if (firstEn !== NCR + 1) begin bad++; $display("[TB] FAIL r2_gap: got %0d expected %0d", firstEn, NCR + 1); end
    total++; if (enCount !== 136 || lastEn - firstEn + 1 !== 136)
      begin bad++; $display("[TB] FAIL r2_len: got %0d (span %0d) expected 136", enCount, lastEn - firstEn + 1); end
    total++; if (got !== {8'h3F, 120'd0, 7'd0, 1'b1})
      begin bad++; $display("[TB] FAIL r2_frame: got %h expected 3f followed by zeros and end bit", got); end
    total++; if (cmdIndex !== expIndex) begin bad++; $display("[TB] FAIL r2_cmd: got %h expected %h", cmdIndex, expIndex); end
  endtask

  task automatic test_start_in_wait;
    logic [5:0]   idx;
    logic [31:0]  arg;
    int           len;
    logic [135:0] bits;
    idx = 6'($urandom_range(0, 63)); arg = $urandom;
    rspType = 2'b01; rspData = {88'd0, $urandom};
    expectedRsp(2'b01, idx, rspData, len, bits);
    sendFrame(hostFrame(idx, arg));
    collect(90, 2, 1'b1);
    expIndex = idx; expArg = arg;
    total++; if (firstEn !== NCR + 1 || enCount !== len || got !== bits)
      begin bad++; $display("[TB] FAIL wait_start: got first=%0d len=%0d bits %h expected first=%0d len=%0d bits %h",
                            firstEn, enCount, got, NCR + 1, len, bits); end
    total++; if (capBusy[n] !== 1'b0) begin bad++; $display("[TB] FAIL wait_idle: got busy %b expected 0", capBusy[n]); end
  endtask

  task automatic test_reset_mid_tx;
    int          k;
    logic [5:0]  idx;
    logic [31:0] arg;
    rspType = 2'b01; rspData = {88'd0, 32'h000001AA};
    sendFrame(48'h48_000001AA_87);
    k = 0;
    while (sdCmdEn !== 1'b1 && k < 20) begin @(negedge sdClk); k++; end
    total++; if (k >= 20) begin bad++; $display("[TB] FAIL rst_tx_start: got no drive expected drive within 20 cycles"); end
    repeat (20) @(negedge sdClk);
    #2 sysRstN = 1'b0;
    #1;
    total++; if ({sdCmdEn, busy, sdCmdOut} !== 3'b001)
      begin bad++; $display("[TB] FAIL rst_tx_abort: got en/busy/out %b expected 001", {sdCmdEn, busy, sdCmdOut}); end
    @(negedge sdClk); @(negedge sdClk); sysRstN = 1'b1;
    repeat (4) @(negedge sdClk);
    expIndex = 6'd0; expArg = 32'd0;
    total++; if (sdCmdEn !== 1'b0 || cmdIndex !== expIndex)
      begin bad++; $display("[TB] FAIL rst_tx_after: got en %b index %h expected 0 0", sdCmdEn, cmdIndex); end
    idx = 6'($urandom_range(0, 63)); arg = $urandom;
    rspType = 2'b00;
    sendFrame(hostFrame(idx, arg));
    collect(8, 0, 1'b0);
    expIndex = idx; expArg = arg;
    total++; if (validAt !== 2 || cmdIndex !== expIndex || cmdArg !== expArg)
      begin bad++; $display("[TB] FAIL rst_tx_next: got at=%0d %h/%h expected at=2 %h/%h", validAt, cmdIndex, cmdArg, expIndex, expArg); end
  endtask

  task automatic test_random;
    logic [5:0]   idx;
    logic [31:0]  arg;
    logic [1:0]   typ;
    logic [127:0] r;
    logic [47:0]  f;
    int           fault, len, pos;
    bit           pass;
    logic [135:0] bits;
    for (int it = 0; it < 10; it++) begin
      idx = 6'($urandom_range(0, 63)); arg = $urandom;
      typ = 2'($urandom_range(0, 3));
      r = {$urandom, $urandom, $urandom, $urandom};
      fault = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 3) : 0;
      f = hostFrame(idx, arg);
      if (fault == 1) begin pos = $urandom_range(8, 46); f[pos] = ~f[pos]; end
      if (fault == 2) f[0] = 1'b0;
      if (fault == 3) f[7:1] = f[7:1] ^ 7'($urandom_range(1, 127));
      pass = (fault == 0);
      rspType = typ; rspData = r[119:0];
      expectedRsp(pass ? typ : 2'b00, idx, r[119:0], len, bits);
      if (pass) begin expIndex = idx; expArg = arg; end
      sendFrame(f);
      collect(len > 0 ? len + 20 : 8, 0, len > 0);
      total++; if (validCount !== int'(pass) || errCount !== int'(!pass) || (pass ? validAt : errAt) !== 2)
        begin bad++; $display("[TB] FAIL rnd%0d_status: got valid=%0d err=%0d expected pass=%0d at cycle 2",
                              it, validCount, errCount, pass); end
      total++; if (enCount !== len || (len > 0 && (firstEn !== NCR + 1 || got !== bits)))
        begin bad++; $display("[TB] FAIL rnd%0d_rsp: got first=%0d len=%0d bits %h expected first=%0d len=%0d bits %h",
                              it, firstEn, enCount, got, NCR + 1, len, bits); end
      total++; if (cmdIndex !== expIndex || cmdArg !== expArg)
        begin bad++; $display("[TB] FAIL rnd%0d_cmd: got %h/%h expected %h/%h", it, cmdIndex, cmdArg, expIndex, expArg); end
    end
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: got no end of run expected finish before time limit");
    $fatal(1, "[TB] time limit reached");
  end

  initial begin
    test_reset();
    test_no_response();
    test_r1();
    test_back_to_back();
    test_bad_crc();
    test_r2();
    test_start_in_wait();
    test_reset_mid_tx();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sd_cmd_responder.md
SD_CMD_RESPONDER -- requirements
Module: sd_cmd_responder

Interface
REQ-001 SHALL have parameter NCR, default 2, giving idle sdClk cycles between the host end bit and the response start bit (legal range 2..64).
REQ-002 SHALL have port sdClk  in  1  the only clock; all state updates and samples on its rising edge.
REQ-003 SHALL have port sysRstN  in  1  reset, asynchronous and active-low.
REQ-004 SHALL have port sdCmdIn  in  1  CMD line as driven by the host.
REQ-005 SHALL have port sdCmdOut  out  1  CMD line response bit.
REQ-006 SHALL have port sdCmdEn  out  1  active-high drive enable for sdCmdOut; the pad tristate is ~sdCmdEn.
REQ-007 SHALL have port cmdIndex  out  6  index of the last accepted command.
REQ-008 SHALL have port cmdArg  out  32  argument of the last accepted command.
REQ-009 SHALL have port cmdValid  out  1  one-cycle pulse when a command passes all checks.
REQ-010 SHALL have port cmdError  out  1  one-cycle pulse when a received frame fails a check.
REQ-011 SHALL have port rspType  in  2  response type: 00 none, 01 R1 (48-bit), 10 R2 (136-bit), 11 treated as 00.
REQ-012 SHALL have port rspData  in  120  response payload: R1 uses [31:0] as status; R2 uses [119:0] as bits 127:8 of CID/CSD.
REQ-013 SHALL have port busy  out  1  high in every state except IDLE.

Function
REQ-014 SHALL implement states IDLE, RX, CHECK, WAIT, TX.
REQ-015 In IDLE, a sampled sdCmdIn=0 is the start bit: SHALL go to RX and shift in the remaining 47 bits, MSB first.
REQ-016 After the 48th bit is sampled, SHALL spend exactly one CHECK cycle.
REQ-017 CHECK SHALL pass only if transmission bit=1, end bit=1, and received CRC7 equals CRC7 (x^7+x^3+1, zero seed) over bits 47..8.
REQ-018 On pass, SHALL pulse cmdValid in the cycle after CHECK and update cmdIndex/cmdArg in the same cycle; both hold until the next accepted command.
REQ-019 On fail, SHALL pulse cmdError, leave cmdIndex/cmdArg unchanged, send no response, and return to IDLE.
REQ-020 rspType and rspData SHALL be sampled in the cmdValid cycle; the user derives them combinationally or by registering from the prior command.
REQ-021 If the sampled rspType is 00 or 11, SHALL return to IDLE with no drive.
REQ-022 Otherwise SHALL enter WAIT, so the line stays undriven for exactly NCR cycles after the host end-bit cycle, then enter TX.
REQ-023 In TX, sdCmdEn=1 for exactly 48 (R1) or 136 (R2) consecutive cycles, registered and glitch-free, then 0 and the block returns to IDLE.
REQ-024 R1 frame SHALL be: 0, 0, cmdIndex[5:0], status[31:0], CRC7 over preceding 40 bits, 1.
REQ-025 R2 frame SHALL be: 0, 0, 111111, rspData[119:0], CRC7 over rspData, 1.
REQ-026 While busy, sdCmdIn SHALL be ignored; a host start bit during WAIT or TX is not detected.
REQ-027 Bit counter SHALL be 8 bits with no wrap inside a frame, and SHALL be cleared on every state entry.
REQ-028 After TX, detection of the next start bit SHALL be possible in the first IDLE cycle.

Reset
REQ-029 On sysRstN low, SHALL enter IDLE immediately (asynchronously), with sdCmdEn=0, sdCmdOut=1, cmdValid=0, cmdError=0, busy=0, cmdIndex=0, cmdArg=0, shift register and CRC cleared.
REQ-030 Reset during RX, WAIT or TX SHALL abort the frame with no further drive; release is synchronous to sdClk.

Verification
REQ-031 Host frame 0x40_00000000_95 with rspType=00 -> cmdValid pulse, cmdIndex=0, cmdArg=0, sdCmdEn never asserted.
REQ-032 Host frame 0x48_000001AA_87 with rspType=01, rspData[31:0]=0x000001AA -> after exactly NCR=2 idle cycles, 48-bit frame 0x08_000001AA_13 with sdCmdEn high for 48 cycles.
REQ-033 Host frame 0x40_00000000_97 (bad CRC) -> cmdError pulse, no cmdValid, no drive, cmdIndex unchanged.
REQ-034 Host frame 0x42_00000000_4D with rspType=10, rspData=0 -> 0x3F, 120 zeros, CRC7=0000000, end 1, sdCmdEn high for 136 cycles.
REQ-035 sysRstN low at TX bit 20 of REQ-032 -> sdCmdEn=0 and busy=0 without a clock edge; the next valid command is accepted normally.
REQ-036 Host start bit injected during WAIT -> ignored; the response in progress completes unchanged.
